// File: rtl/tx_uart.sv
// UART transmitter: start, NB_DATA bits LSB first, optional parity, N_STOP stops; all outputs registered.
// Line goes low the cycle after start is accepted; start requests while busy are dropped (no queueing).
module tx_uart #(
    parameter int NB_DATA    = 8,
    parameter int N_STOP     = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done_tick
);
    localparam int TICK_W = $clog2(N_STOP * OVERSAMPLE);
    localparam int BIT_W  = $clog2(NB_DATA);

    localparam logic [TICK_W-1:0] LAST_BIT_TICK  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] LAST_STOP_TICK = TICK_W'(N_STOP * OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT       = BIT_W'(NB_DATA - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // tx_d always carries the level of the bit being entered, so o_tx is a plain flop output
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_tx_start) begin
                    shift_d    = i_data;
                    par_d      = (^i_data) ^ (PARITY_ODD != 0);
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt_q == LAST_BIT_TICK) begin
                        tick_cnt_d = '0;
                        state_d    = DATA;
                        tx_d       = shift_q[0];
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == LAST_BIT_TICK) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            if (PARITY_EN != 0) begin
                                state_d = PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            tx_d      = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            PARITY: begin
                if (i_tick) begin
                    if (tick_cnt_q == LAST_BIT_TICK) begin
                        tick_cnt_d = '0;
                        state_d    = STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == LAST_STOP_TICK) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_tx           = tx_q;
    assign o_busy         = busy_q;
    assign o_tx_done_tick = done_q;
endmodule

// File: tb/tb_tx_uart.sv
// Drives three tx_uart variants (8N1, 8E2, 8O2) with shared stimulus; each is checked every cycle
// against a frame-bit/tick-count model.
module tb_tx_uart;
    logic       i_clock;
    logic       i_reset;
    logic       i_tick;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx_a, o_busy_a, o_done_a;
    logic       o_tx_b, o_busy_b, o_done_b;
    logic       o_tx_c, o_busy_c, o_done_c;

    tx_uart dut_a (
        .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(i_tx_start),
        .i_data(i_data), .o_tx(o_tx_a), .o_busy(o_busy_a), .o_tx_done_tick(o_done_a)
    );
    tx_uart #(.N_STOP(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(i_tx_start),
        .i_data(i_data), .o_tx(o_tx_b), .o_busy(o_busy_b), .o_tx_done_tick(o_done_b)
    );
    tx_uart #(.N_STOP(2), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(i_tx_start),
        .i_data(i_data), .o_tx(o_tx_c), .o_busy(o_busy_c), .o_tx_done_tick(o_done_c)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    localparam int OS = 16;
    int m_ns   [3] = '{1, 2, 2};
    int m_pen  [3] = '{0, 1, 1};
    int m_podd [3] = '{0, 0, 1};

    // Reference: a frame is a list of bit levels; the line shows bit (ticks_counted / OS)
    bit m_bits   [3][16];
    bit m_act    [3];
    bit m_done   [3];
    int m_ticks  [3];
    int m_total  [3];
    int m_acc    [3];

    int done_cnt [3];
    int busy_cyc [3];
    int idle_cyc [3];
    int last_done[3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tick_mode = 0;
    int tph     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            m_done[k] = 1'b0;
            if (i_reset) begin
                m_act[k] = 1'b0;
            end else if (!m_act[k]) begin
                if (i_tx_start) begin
                    int nb;
                    nb = 1 + 8 + m_pen[k] + m_ns[k];
                    for (int i = 0; i < 16; i++) m_bits[k][i] = 1'b1;
                    m_bits[k][0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_bits[k][1+i] = i_data[i];
                    if (m_pen[k] != 0) m_bits[k][9] = (^i_data) ^ m_podd[k][0];
                    m_total[k] = OS * nb;
                    m_ticks[k] = 0;
                    m_act[k]   = 1'b1;
                    m_acc[k]   = cyc;
                end
            end else if (i_tick) begin
                m_ticks[k]++;
                if (m_ticks[k] == m_total[k]) begin
                    m_act[k]  = 1'b0;
                    m_done[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 3; k++) begin
            done_cnt[k] = 0; busy_cyc[k] = 0; idle_cyc[k] = 0;
        end
    endtask

    task automatic step();
        logic [2:0] obs [3];
        logic [2:0] exp;
        @(posedge i_clock);
        cyc++;
        model_edge();
        @(negedge i_clock);
        obs[0] = {o_tx_a, o_busy_a, o_done_a};
        obs[1] = {o_tx_b, o_busy_b, o_done_b};
        obs[2] = {o_tx_c, o_busy_c, o_done_c};
        for (int k = 0; k < 3; k++) begin
            exp = {(m_act[k] ? m_bits[k][m_ticks[k] / OS] : 1'b1), m_act[k], m_done[k]};
            check($sformatf("line%0d{tx,busy,done}", k), obs[k], exp);
            if (obs[k][0]) begin done_cnt[k]++; last_done[k] = cyc; end
            if (obs[k][1]) busy_cyc[k]++; else idle_cyc[k]++;
        end
        case (tick_mode)
            0: i_tick = 1'b0;
            1: begin tph = (tph + 1) % 4; i_tick = (tph == 0); end
            default: i_tick = ($urandom_range(0, 2) == 0);
        endcase
    endtask

    // The tick generator is re-phased so a tick coincides with the accepting edge (must not count)
    task automatic send(input logic [7:0] d, input int mode);
        i_data     = d;
        i_tx_start = 1'b1;
        tick_mode  = mode;
        tph        = 0;
        i_tick     = (mode == 1);
        step();
        i_tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_act[0] || m_act[1] || m_act[2]) && n < 5000) begin
            step();
            n++;
        end
        check("idle_within_budget", (n < 5000), 1);
    endtask

    initial begin
        i_reset = 1'b1; i_tick = 1'b0; i_tx_start = 1'b0; i_data = 8'h00;
        repeat (3) step();
        check("reset_a", {o_tx_a, o_busy_a, o_done_a}, 3'b100);
        check("reset_b", {o_tx_b, o_busy_b, o_done_b}, 3'b100);
        i_reset = 1'b0;
        step();

        // 0xA5 on 8N1: 160 ticks at one per 4 clocks
        clear_counts();
        send(8'hA5, 1);
        wait_idle();
        check("a5_busy_cycles", busy_cyc[0], 640);
        check("a5_done_count", done_cnt[0], 1);
        check("a5_done_latency", last_done[0] - m_acc[0], 640);
        check("8e2_done_latency", last_done[1] - m_acc[1], 768);
        step();

        // 0x07: parity bit (frame bit 9) and second stop bit
        clear_counts();
        send(8'h07, 1);
        while (cyc < m_acc[1] + 608) step();
        check("par_even_07", o_tx_b, 1'b1);
        check("par_odd_07", o_tx_c, 1'b0);
        while (cyc < m_acc[1] + 720) step();
        check("stop2_b", {o_tx_b, o_busy_b}, 2'b11);
        wait_idle();
        check("07_done_b", done_cnt[1], 1);
        check("07_done_c", done_cnt[2], 1);
        step();

        // Start request and data change mid-frame are ignored
        clear_counts();
        send(8'hFF, 1);
        repeat (200) step();
        i_data = 8'h3C; i_tx_start = 1'b1;
        step();
        i_tx_start = 1'b0; i_data = 8'($urandom);
        wait_idle();
        check("midreq_done_a", done_cnt[0], 1);
        check("midreq_done_c", done_cnt[2], 1);
        step();

        // Held start: each done is followed by exactly one idle-high cycle
        send(8'h55, 1);
        i_tx_start = 1'b1;
        clear_counts();
        begin
            int n;
            n = 0;
            while (done_cnt[0] < 3 && n < 4000) begin step(); n++; end
        end
        check("held_done_a", done_cnt[0], 3);
        check("held_idle_a", idle_cyc[0], 3);
        i_tx_start = 1'b0;
        wait_idle();
        step();

        // Reset during data bit 3 aborts the frame; a clean frame follows
        send(8'h96, 1);
        while (cyc < m_acc[0] + 280) step();
        clear_counts();
        i_reset = 1'b1;
        step();
        check("midrst_a", {o_tx_a, o_busy_a, o_done_a}, 3'b100);
        i_reset = 1'b0;
        step();
        check("midrst_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);
        clear_counts();
        send(8'h3B, 1);
        wait_idle();
        check("after_rst_done_a", done_cnt[0], 1);
        step();

        // No ticks: stays in the start bit
        send(8'hC3, 0);
        repeat (1000) step();
        check("notick_a", {o_tx_a, o_busy_a}, 2'b01);
        check("notick_b", {o_tx_b, o_busy_b}, 2'b01);
        tick_mode = 1;
        wait_idle();
        step();

        // Random ticks, data, starts and occasional resets
        tick_mode = 2;
        for (int i = 0; i < 6000; i++) begin
            i_data     = 8'($urandom);
            i_tx_start = ($urandom_range(0, 29) == 0);
            i_reset    = ($urandom_range(0, 799) == 0);
            step();
        end
        i_tx_start = 1'b0;
        i_reset    = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_uart.md
Name: tx_uart

Overview:
UART transmitter, the transmit-side counterpart of the team's 16x-oversampled UART receiver. It serializes one parallel byte into a frame on o_tx: start bit, NB_DATA data bits LSB first, optional parity bit, then N_STOP stop bits. Bit timing comes from an external baud-rate generator that supplies a single-cycle i_tick enable at OVERSAMPLE times the baud rate. The block sits between the host-side interface logic and the serial TX pin.

Parameters:
NB_DATA, 8, data bits per frame (5..8)
N_STOP, 1, stop bits (1 or 2)
OVERSAMPLE, 16, i_tick pulses per bit period
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_tick  in  1  baud-gen enable, 1-cycle pulse, OVERSAMPLE per bit
i_tx_start  in  1  request to send i_data, sampled each cycle
i_data  in  NB_DATA  byte to transmit, captured on accepted start
o_tx  out  1  serial line, idles high
o_busy  out  1  high while a frame is in progress
o_tx_done_tick  out  1  1-cycle pulse when the last stop bit completes

Behaviour:
- Reset: already decided — reset i_reset, synchronous, active-high; clock i_clock. On reset: state IDLE, o_tx=1, o_busy=0, o_tx_done_tick=0, all counters and the shift register cleared. Reset mid-frame aborts the frame; o_tx is 1 on the next edge and no done pulse is issued.
- All outputs are registered; o_tx never glitches.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1, o_busy=0. If i_tx_start=1, capture i_data into the shift register, compute parity, clear tick_cnt and bit_cnt, and go to START. The edge that accepts start is cycle N. From N+1: o_tx=0, o_busy=1.
- tick_cnt advances only on cycles with i_tick=1. An i_tick coincident with the accepting cycle N is not counted.
- START: after OVERSAMPLE counted ticks, clear tick_cnt and go to DATA. o_tx presents shift[0].
- DATA: each bit lasts OVERSAMPLE ticks, then shift right and increment bit_cnt. After bit NB_DATA-1, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: o_tx = XOR of the data bits, inverted if PARITY_ODD=1. Lasts OVERSAMPLE ticks, then go to STOP.
- STOP: o_tx=1 for N_STOP*OVERSAMPLE ticks. On the cycle the final tick is counted, pulse o_tx_done_tick=1 for exactly one clock and go to IDLE. o_busy falls on the same edge that raises the done pulse.
- i_tx_start while o_busy=1 is ignored, and i_data changes mid-frame have no effect. i_tx_start on the done-pulse cycle is also ignored (state is not yet IDLE). It is accepted from the following cycle, giving back-to-back frames with a single idle-high clock between them.
- Held i_tx_start: a new frame starts each time IDLE is reached.
- Counter widths: tick_cnt is $clog2(N_STOP*OVERSAMPLE) bits. bit_cnt is $clog2(NB_DATA) bits, wrapping only under reset/clear. No counter may overflow inside a state.
- Frame length in ticks = OVERSAMPLE*(1+NB_DATA+PARITY_EN+N_STOP).

Test Plan:
- Defaults, i_tick every 4 clocks, send 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 ticks (64 clocks). One done pulse 640 clocks after acceptance, o_busy high for exactly that window.
- PARITY_EN=1, PARITY_ODD=0, N_STOP=2, send 0x07 -> parity bit 1, then 32 ticks of stop high. Repeat with PARITY_ODD=1 -> parity bit 0.
- Pulse i_tx_start with 0x3C mid-frame of 0xFF -> second request ignored, only 0xFF is transmitted, one done pulse.
- i_tx_start held high with i_data=0x55 -> consecutive frames separated by exactly one idle-high clock, one done pulse per frame.
- Assert i_reset during DATA bit 3 -> next edge o_tx=1, o_busy=0, no done pulse. A start 2 cycles later transmits a clean full frame.
- i_tick held low for 1000 clocks after start -> o_tx stays 0 (start bit), o_busy=1, no state advance.
